// File: rtl/writeback_unit_pkg.sv
// Common types and constants for the writeback unit.
package writeback_unit_pkg;

  `include "common_library.vh"

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_ALU    = 2'd1,
    SRC_FIFO   = 2'd2,
    SRC_BYPASS = 2'd3
  } wb_src_e;

endpackage

// File: rtl/common_library.vh
// Shared load-type encodings and load-queue sizing for the writeback stage.
localparam logic [2:0] LD_LB  = 3'b000;
localparam logic [2:0] LD_LH  = 3'b001;
localparam logic [2:0] LD_LW  = 3'b010;
localparam logic [2:0] LD_LBU = 3'b100;
localparam logic [2:0] LD_LHU = 3'b101;

localparam int unsigned WB_FIFO_DEPTH = 2;
localparam int unsigned WB_FIFO_PTR_W = $clog2(WB_FIFO_DEPTH);

// File: rtl/wb_load_fifo.sv
// Small load-result queue holding {rd, formatted data}; pointers wrap naturally.
module wb_load_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Reset only the pointers; stale storage is unreachable once they are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU and load results onto the register-file write port,
// formats load data and tracks pending loads. Define WB_FWD_EN to enable write forwarding.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned RF_ADDR_LEN = 5,
  parameter int unsigned RF_DATA_LEN = 32,
  parameter int unsigned FIFO_DEPTH  = WB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [RF_ADDR_LEN-1:0] alu_rd,
  input  logic [RF_DATA_LEN-1:0] alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [RF_ADDR_LEN-1:0] lsu_rd,
  input  logic [2:0]             lsu_funct3,
  input  logic [1:0]             lsu_byte_off,
  input  logic [RF_DATA_LEN-1:0] lsu_rdata,
  input  logic                   load_issue,
  input  logic [RF_ADDR_LEN-1:0] load_issue_rd,
  input  logic [RF_ADDR_LEN-1:0] rs1_addr,
  input  logic [RF_ADDR_LEN-1:0] rs2_addr,
  output logic                   rs1_pending,
  output logic                   rs2_pending,
  output logic                   w_en,
  output logic [RF_ADDR_LEN-1:0] rd_addr,
  output logic [RF_DATA_LEN-1:0] rd_write_data,
  output logic                   fwd_rs1_hit,
  output logic                   fwd_rs2_hit,
  output logic [RF_DATA_LEN-1:0] fwd_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = RF_ADDR_LEN + RF_DATA_LEN;
  localparam int unsigned NREG  = 1 << RF_ADDR_LEN;
  localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  logic                   w_en_q, w_en_d;
  logic [RF_ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
  logic [RF_DATA_LEN-1:0] rd_data_q, rd_data_d;
  logic [NREG-1:0]        pending_q, pending_d;

  wb_src_e                src;
  logic                   load_wr;
  logic                   ld_keep;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [RF_DATA_LEN-1:0] ld_data;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]       fifo_head;
  logic [PTR_W:0]         fifo_count;
  logic [RF_ADDR_LEN-1:0] head_rd;
  logic [RF_DATA_LEN-1:0] head_data;

  assign lsu_ready = (fifo_count < CNT_DEPTH);
  assign ld_keep   = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign head_rd   = fifo_head[ENT_W-1 -: RF_ADDR_LEN];
  assign head_data = fifo_head[RF_DATA_LEN-1:0];

  // Load extraction and extension happen once, at acceptance.
  assign ld_byte = lsu_rdata[{lsu_byte_off, 3'b000} +: 8];
  assign ld_half = lsu_byte_off[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];

  always_comb begin
    ld_data = '0;
    case (lsu_funct3)
      LD_LB:   ld_data = {{(RF_DATA_LEN - 8){ld_byte[7]}}, ld_byte};
      LD_LH:   ld_data = {{(RF_DATA_LEN - 16){ld_half[15]}}, ld_half};
      LD_LW:   ld_data = lsu_rdata;
      LD_LBU:  ld_data = {{(RF_DATA_LEN - 8){1'b0}}, ld_byte};
      LD_LHU:  ld_data = {{(RF_DATA_LEN - 16){1'b0}}, ld_half};
      default: ld_data = '0;
    endcase
  end

  wb_load_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({lsu_rd, ld_data}),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Priority: ALU, then queued loads, then a fresh load straight through.
  always_comb begin
    src       = SRC_NONE;
    w_en_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    load_wr   = 1'b0;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;

    if (alu_valid)        src = SRC_ALU;
    else if (!fifo_empty) src = SRC_FIFO;
    else if (ld_keep)     src = SRC_BYPASS;

    case (src)
      SRC_ALU: begin
        if (alu_rd != '0) begin
          w_en_d    = 1'b1;
          rd_addr_d = alu_rd;
          rd_data_d = alu_data;
        end
      end
      SRC_FIFO: begin
        w_en_d    = 1'b1;
        rd_addr_d = head_rd;
        rd_data_d = head_data;
        load_wr   = 1'b1;
        fifo_pop  = 1'b1;
      end
      SRC_BYPASS: begin
        w_en_d    = 1'b1;
        rd_addr_d = lsu_rd;
        rd_data_d = ld_data;
        load_wr   = 1'b1;
      end
      default: ;
    endcase

    fifo_push = ld_keep && (src != SRC_BYPASS) && !fifo_full;
  end

  // Issue sets after the writeback clear so a same-cycle collision stays pending.
  always_comb begin
    pending_d = pending_q;
    if (load_wr) pending_d[rd_addr_d] = 1'b0;
    if (load_issue && (load_issue_rd != '0)) pending_d[load_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en_q    <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      pending_q <= '0;
    end else begin
      w_en_q    <= w_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      pending_q <= pending_d;
    end
  end

  assign w_en          = w_en_q;
  assign rd_addr       = rd_addr_q;
  assign rd_write_data = rd_data_q;
  assign rs1_pending   = pending_q[rs1_addr];
  assign rs2_pending   = pending_q[rs2_addr];

`ifdef WB_FWD_EN
  assign fwd_rs1_hit = w_en_q && (rd_addr_q != '0) && (rd_addr_q == rs1_addr);
  assign fwd_rs2_hit = w_en_q && (rd_addr_q != '0) && (rd_addr_q == rs2_addr);
  assign fwd_data    = rd_data_q;
`else
  assign fwd_rs1_hit = 1'b0;
  assign fwd_rs2_hit = 1'b0;
  assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic vs a queue model.
module tb_writeback_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_byte_off;
  logic [31:0] lsu_rdata;
  logic        load_issue;
  logic [4:0]  load_issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_pending;
  logic        rs2_pending;
  logic        w_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_write_data;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_funct3    (lsu_funct3),
    .lsu_byte_off  (lsu_byte_off),
    .lsu_rdata     (lsu_rdata),
    .load_issue    (load_issue),
    .load_issue_rd (load_issue_rd),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_pending   (rs1_pending),
    .rs2_pending   (rs2_pending),
    .w_en          (w_en),
    .rd_addr       (rd_addr),
    .rd_write_data (rd_write_data),
    .fwd_rs1_hit   (fwd_rs1_hit),
    .fwd_rs2_hit   (fwd_rs2_hit),
    .fwd_data      (fwd_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: loads waiting behind the ALU, pending bits, expected write port.
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  bit          pend[32];
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock: drive at the falling edge, check combinational outputs, predict, check the write.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                      input logic [1:0] off, input logic [31:0] rdata,
                      input logic li, input logic [4:0] lird,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit          acc;
    bit          ldw;
    logic [4:0]  ldrd;
    logic        nw;
    logic [4:0]  na;
    logic [31:0] nd;
    logic        e_h1, e_h2;
    logic [31:0] e_fd;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_funct3 = f3; lsu_byte_off = off; lsu_rdata = rdata;
    load_issue = li; load_issue_rd = lird; rs1_addr = r1; rs2_addr = r2;
    #1;
    check("lsu_ready", lsu_ready, q_rd.size() < DEPTH);
    check("rs1_pending", rs1_pending, pend[r1]);
    check("rs2_pending", rs2_pending, pend[r2]);
`ifdef WB_FWD_EN
    e_h1 = m_wen && (m_addr != 0) && (m_addr == r1);
    e_h2 = m_wen && (m_addr != 0) && (m_addr == r2);
    e_fd = m_data;
`else
    e_h1 = 1'b0;
    e_h2 = 1'b0;
    e_fd = 32'h0;
`endif
    check("fwd_rs1_hit", fwd_rs1_hit, e_h1);
    check("fwd_rs2_hit", fwd_rs2_hit, e_h2);
    check("fwd_data", fwd_data, e_fd);

    acc  = lv && (q_rd.size() < DEPTH);
    ldw  = 1'b0;
    ldrd = '0;
    nw   = 1'b0;
    na   = m_addr;
    nd   = m_data;
    if (av) begin
      if (ard != 0) begin nw = 1'b1; na = ard; nd = ad; end
    end else if (q_rd.size() > 0) begin
      nw = 1'b1; na = q_rd.pop_front(); nd = q_data.pop_front(); ldw = 1'b1; ldrd = na;
    end else if (acc && lrd != 0) begin
      nw = 1'b1; na = lrd; nd = fmt(f3, off, rdata); ldw = 1'b1; ldrd = lrd; acc = 1'b0;
    end
    if (acc && lrd != 0) begin
      q_rd.push_back(lrd);
      q_data.push_back(fmt(f3, off, rdata));
    end
    if (ldw) pend[ldrd] = 1'b0;
    if (li && lird != 0) pend[lird] = 1'b1;
    m_wen = nw; m_addr = na; m_data = nd;

    @(negedge clk);
    check("w_en", w_en, m_wen);
    check("rd_addr", rd_addr, m_addr);
    check("rd_write_data", rd_write_data, m_data);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0, 1'b0, 5'd0, r1, r2);
  endtask

  task automatic lw(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                    input logic [4:0] lrd, input logic [31:0] rdata);
    step(av, ard, ad, 1'b1, lrd, 3'b010, 2'd0, rdata, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  logic [2:0]  ext_f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
  logic [1:0]  ext_off[5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] ext_exp[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0};

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_byte_off = 0; lsu_rdata = 0;
    load_issue = 0; load_issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_w_en", w_en, 1'b0);
    check("rst_rd_addr", rd_addr, 5'd0);
    check("rst_rd_data", rd_write_data, 32'h0);
    check("rst_lsu_ready", lsu_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // ALU/load collision
    lw(1'b1, 5'd3, 32'h11, 5'd4, 32'hDEADBEEF);
    check("coll_alu_addr", rd_addr, 5'd3);
    check("coll_alu_data", rd_write_data, 32'h11);
    idle(5'd0, 5'd0);
    check("coll_ld_addr", rd_addr, 5'd4);
    check("coll_ld_data", rd_write_data, 32'hDEADBEEF);

    // Backpressure: ALU held 4 cycles, three loads offered
    lw(1'b1, 5'd1, 32'hA1, 5'd11, 32'h100);
    lw(1'b1, 5'd2, 32'hA2, 5'd12, 32'h200);
    check("bp_ready_low", lsu_ready, 1'b0);
    lw(1'b1, 5'd3, 32'hA3, 5'd13, 32'h300);
    lw(1'b1, 5'd5, 32'hA4, 5'd13, 32'h300);
    lw(1'b0, 5'd0, 32'h0,  5'd13, 32'h300);
    check("bp_first_load", rd_addr, 5'd11);
    check("bp_ready_back", lsu_ready, 1'b1);
    lw(1'b0, 5'd0, 32'h0,  5'd13, 32'h300);
    check("bp_second_load", rd_addr, 5'd12);
    idle(5'd0, 5'd0);
    check("bp_third_addr", rd_addr, 5'd13);
    check("bp_third_data", rd_write_data, 32'h300);
    idle(5'd0, 5'd0);

    // Load extension
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, ext_f3[i], ext_off[i], 32'h80FF7F01,
           1'b0, 5'd0, 5'd0, 5'd0);
      check($sformatf("ext%0d", i), rd_write_data, ext_exp[i]);
    end

    // Scoreboard
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    check("sb_set", rs1_pending, 1'b1);
    idle(5'd7, 5'd0);
    check("sb_hold", rs1_pending, 1'b1);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'b010, 2'd0, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    check("sb_clear", rs1_pending, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'b010, 2'd0, 32'h78, 1'b1, 5'd7, 5'd7, 5'd0);
    check("sb_set_wins", rs1_pending, 1'b1);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 3'b010, 2'd0, 32'h79, 1'b0, 5'd0, 5'd7, 5'd0);
    check("sb_clear2", rs1_pending, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    check("sb_x0", rs1_pending, 1'b0);

    // x0 and forwarding
    step(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("x0_alu_w_en", w_en, 1'b0);
    step(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
`ifdef WB_FWD_EN
    check("fwd_x9_hit", fwd_rs2_hit, 1'b1);
    check("fwd_x9_data", fwd_data, 32'h1234);
`else
    check("fwd_x9_hit", fwd_rs2_hit, 1'b0);
    check("fwd_x9_data", fwd_data, 32'h0);
`endif
    idle(5'd0, 5'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic       li;
      logic [4:0] lird;
      lird = 5'($urandom_range(0, 31));
      li   = ($urandom_range(0, 3) == 0) && !pend[lird];
      step(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom, li, lird,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    repeat (4) idle(5'd0, 5'd0);

    // Reset mid-operation with a full queue
    lw(1'b1, 5'd1, 32'hB1, 5'd20, 32'h2000);
    lw(1'b1, 5'd2, 32'hB2, 5'd21, 32'h2100);
    check("mid_pre_w_en", w_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_w_en", w_en, 1'b0);
    check("mid_rst_ready", lsu_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 3'b000, 2'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("mid_x5_addr", rd_addr, 5'd5);
    check("mid_x5_data", rd_write_data, 32'h5555);
    idle(5'd0, 5'd0);
    check("mid_alone", w_en, 1'b0);
    idle(5'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage directly upstream of the register file; sole driver of its write port (w_en, rd_addr, rd_write_data).
- Merges two result sources: single-cycle ALU results, and load data returned by the LSU.
- ALU has fixed priority. Colliding load results are queued in a small FIFO.
- Load data is extracted and sign/zero-extended here. A pending-load scoreboard tells decode which source registers are still awaiting load data.

Parameters:
- RF_ADDR_LEN, 5, register address width.
- RF_DATA_LEN, 32, data width.
- FIFO_DEPTH, 2, load queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle; always accepted, no ready
- alu_rd  in  RF_ADDR_LEN  ALU destination register
- alu_data  in  RF_DATA_LEN  ALU result
- lsu_valid  in  1  load data present
- lsu_ready  out  1  unit can accept load data
- lsu_rd  in  RF_ADDR_LEN  load destination register
- lsu_funct3  in  3  load type
- lsu_byte_off  in  2  address[1:0] of the load
- lsu_rdata  in  RF_DATA_LEN  raw aligned memory word
- load_issue  in  1  decode issues a load this cycle
- load_issue_rd  in  RF_ADDR_LEN  destination of the issued load
- rs1_addr  in  RF_ADDR_LEN  decode source 1
- rs2_addr  in  RF_ADDR_LEN  decode source 2
- rs1_pending  out  1  rs1 awaits load data
- rs2_pending  out  1  rs2 awaits load data
- w_en  out  1  register file write enable (registered)
- rd_addr  out  RF_ADDR_LEN  register file write address (registered)
- rd_write_data  out  RF_DATA_LEN  register file write data (registered)
- fwd_rs1_hit  out  1  see Optional Feature
- fwd_rs2_hit  out  1  see Optional Feature
- fwd_data  out  RF_DATA_LEN  see Optional Feature

Behaviour:
- Reset (async, any time):
  - w_en=0, rd_addr=0, rd_write_data=0.
  - FIFO emptied; in-flight entries are discarded.
  - All pending bits cleared; lsu_ready=1 from the first cycle after reset release.
- Load acceptance:
  - A load is accepted on lsu_valid && lsu_ready.
  - lsu_ready = (count < FIFO_DEPTH). It depends on registered count only; no path from alu_valid or lsu_valid.
  - A full FIFO holds ready=0 even in a cycle where it pops.
- Load formatting, applied at acceptance:
  - 000 LB: byte at lsu_byte_off, sign-extended.
  - 001 LH: halfword at lsu_byte_off[1], sign-extended; lsu_byte_off[0] ignored.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: as LB / LH, zero-extended.
  - Any other funct3: data 0.
- Arbitration, one write per cycle, outputs registered at the next clock edge:
  - alu_valid wins; ALU result latency is 1 cycle.
  - Else FIFO non-empty: pop the head.
  - Else an accepted load bypasses the FIFO and writes with latency 1.
  - Otherwise, an accepted load is pushed. Push and pop in the same cycle keep count unchanged.
  - Loads leave in acceptance order.
- x0 handling:
  - ALU with rd=0: w_en=0 that cycle.
  - Load with rd=0: accepted, then dropped; never enqueued.
- Scoreboard (one bit per register):
  - Bit set at the edge where load_issue=1 for load_issue_rd; x0 never set.
  - Bit cleared at the edge where a load write to that rd is registered.
  - Set and clear of the same rd in one cycle: set wins.
  - rsN_pending = pending[rsN_addr], combinational.
  - Decode must not issue a second load to a pending rd.
- FIFO wrap: read/write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- WB_FWD_EN defined:
  - fwd_rsN_hit = w_en && rd_addr!=0 && rd_addr==rsN_addr.
  - fwd_data = rd_write_data.
  - Lets decode obtain the value being written this cycle, which the register file exposes only after the edge.
- Undefined: fwd_rs1_hit=0, fwd_rs2_hit=0, fwd_data=0; no comparators synthesised.

Decomposition:
- Load funct3 encodings and the FIFO pointer width go in common_library.vh as localparams, included as the codebase does.
- Sub-module wb_load_fifo:
  - Stores {rd, formatted data}.
  - Exposes push, pop, head, count, full and empty.
  - Has the same async reset.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill FIFO with 2 loads, assert rst asynchronously.
  - Response: w_en=0 and lsu_ready=1 without waiting for a clock edge; the next ALU write to x5 appears alone.
- ALU/load collision:
  - Stimulus: alu_valid rd=3 data=0x11 together with load LW rd=4 data=0xDEADBEEF.
  - Response: cycle+1 writes x3=0x11; cycle+2 writes x4=0xDEADBEEF.
- Backpressure:
  - Stimulus: alu_valid held 4 cycles while 3 loads are offered.
  - Response: lsu_ready drops after 2 accepts; the third load is held, accepted later, and all are written in order.
- Load extension:
  - Stimulus: lsu_rdata=0x80FF7F01.
  - Response:
    - LB off=3 -> 0xFFFFFF80.
    - LBU off=3 -> 0x00000080.
    - LH off=2 -> 0xFFFF80FF.
    - LHU off=0 -> 0x00007F01.
    - funct3=011 -> 0.
- Scoreboard:
  - Stimulus: load_issue rd=7, then rs1_addr=7, then the load returns for x7.
  - Response: rs1_pending=1 until the edge registering the x7 write, then 0. Setting and clearing x7 in the same cycle leaves it 1. load_issue rd=0 never sets a bit.
- x0 and forwarding:
  - Stimulus: ALU rd=0 data=0x55.
  - Response: w_en=0.
  - With WB_FWD_EN defined: a write to x9 with rs2_addr=9 gives fwd_rs2_hit=1 and fwd_data equal to the written value.
